decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Registered MIPS instruction-decode stage. It replaces the purely combinational field split with an ID/EX pipeline register that has a valid/ready handshake. The stage generates immediates per opcode (sign, zero or lui), computes branch and jump targets, detects load-use hazards and inserts one bubble, and supports a synchronous flush. It sits between the IF/ID register and the execute stage.

Parameters:
DATA_W, 32, datapath/PC width; must be >= 32.
CNT_W, 16, width of the saturating stall counter.
LOGIC_SEXT, 0, 1 = andi/ori/xori sign-extend imm; 0 = zero-extend (MIPS semantics).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID presents an instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc4  in  DATA_W  PC+4 of the instruction
flush  in  1  synchronous kill of stage contents
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  execute stage accepts
out_opcode  out  6  instr[31:26]
out_rs / out_rt / out_rd  out  5 each  instr[25:21] / [20:16] / [15:11]
out_shamt  out  5  instr[10:6]
out_funct  out  6  instr[5:0]
out_imm  out  DATA_W  extended immediate
out_btarget  out  DATA_W  in_pc4 + (sext(imm16) << 2)
out_jtarget  out  DATA_W  {in_pc4[DATA_W-1:28], instr[25:0], 2'b00}
out_pc4  out  DATA_W  registered in_pc4
hazard  out  1  load-use stall active this cycle
stall_count  out  CNT_W  number of bubbles inserted

Behaviour:
- Reset (rst_n=0, async): every registered output is 0, including out_valid and stall_count. in_ready and hazard are combinational from registered state and inputs.
- Latency: 1 cycle. The register loads when advance = (!out_valid | out_ready).
- is_load(op) = op in {0x20,0x21,0x23,0x24,0x25}.
- uses_rt(op) = op in {0x00,0x04,0x05,0x28,0x29,0x2B}.
- hazard = in_valid & out_valid & is_load(out_opcode) & out_rt!=0 & (out_rt==instr[25:21] | (uses_rt(instr[31:26]) & out_rt==instr[20:16])).
- in_ready = advance & !hazard & !flush.
- Priority each cycle: flush, then advance:
  - flush=1: out_valid<=0. Input is not accepted. stall_count is unchanged.
  - advance & hazard: out_valid<=0, a bubble. Data fields hold their previous values. stall_count increments, saturating at 2^CNT_W-1. The instruction stays on the input and is accepted next cycle with no hazard, so exactly 1 bubble is inserted per load-use.
  - advance & in_valid & !hazard: capture all fields and set out_valid<=1.
  - advance & !in_valid: out_valid<=0.
  - !advance: hold all outputs.
- Immediate generation (imm16 = instr[15:0]):
  - op 0x0F (lui): {imm16,16'b0} sign-extended from bit 31 to DATA_W.
  - op 0x0C/0x0D/0x0E: zero-extended, or sign-extended if LOGIC_SEXT=1.
  - All other opcodes: sign-extended.
- Arithmetic: out_btarget is computed modulo 2^DATA_W, with wrap-around permitted.
- Fields are registered regardless of opcode legality; no illegal-op trap.
- Reset mid-transfer discards the held instruction. in_ready returns to 1 on the first cycle after release, assuming no flush.

Test Plan:
- Reset, then in_instr=0x3C011234 (lui $1), in_pc4=0x00400004, out_ready=1 -> next cycle out_valid=1, out_rt=1, out_imm=0x12340000.
- Two single-instruction transactions, out_ready=1:
  - 0x3422FFFF (ori) -> out_imm=0x0000FFFF.
  - 0x2003FFFF (addi) -> out_imm=0xFFFFFFFF.
- Same sequence with LOGIC_SEXT=1 -> ori out_imm=0xFFFFFFFF.
- Branch/jump targets, in_pc4=0x00400010:
  - 0x1000FFFE (beq, imm=-2) -> out_btarget=0x00400008.
  - 0x08100003 -> out_jtarget=0x0040000C.
- 0x8D280000 (lw $8,0($9)), then 0x010B5020 (add $10,$8,$11), out_ready=1:
  - 1 cycle with hazard=1 and in_ready=0, then a bubble (out_valid=0), then the add issues.
  - stall_count=1.
  - Repeat with lw $0 -> no stall.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0. Then out_ready=1 -> next instruction loads.
- Two flush cases, each checked for stall_count unchanged:
  - flush=1 while out_valid=1 -> out_valid=0 next cycle, input not consumed.
  - flush together with hazard -> flush wins.
- Assert rst_n=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage_pipe_if.sv
// Handshake and field bus between IF/ID, the decode stage and execute.
// The slave view belongs to the decode stage; the master view is its environment.
interface decode_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc4;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [5:0]        out_funct;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_btarget;
    logic [DATA_W-1:0] out_jtarget;
    logic [DATA_W-1:0] out_pc4;
    logic              hazard;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output in_valid, in_instr, in_pc4, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
               out_funct, out_imm, out_btarget, out_jtarget, out_pc4, hazard, stall_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc4, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
               out_funct, out_imm, out_btarget, out_jtarget, out_pc4, hazard, stall_count
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered MIPS decode stage: splits the instruction into fields, builds the
// immediate and branch/jump targets, and holds them in an ID/EX register with a
// valid/ready handshake. A load followed by a dependent instruction costs one bubble.
// DATA_W must be at least 32.
module decode_stage_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 16,
    parameter bit          LOGIC_SEXT = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    decode_stage_pipe_if.slave bus
);

    function automatic logic is_load(input logic [5:0] opc);
        return opc inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] opc);
        return opc inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    endfunction

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign op    = bus.in_instr[31:26];
    assign rs    = bus.in_instr[25:21];
    assign rt    = bus.in_instr[20:16];
    assign rd    = bus.in_instr[15:11];
    assign shamt = bus.in_instr[10:6];
    assign funct = bus.in_instr[5:0];
    assign imm16 = bus.in_instr[15:0];

    logic [DATA_W-1:0] sext16;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] btarget;
    logic [DATA_W-1:0] jtarget;

    // Immediate extension selected by opcode; lui result is sign-extended from bit 31.
    always_comb begin
        sext16  = DATA_W'($signed(imm16));
        imm_ext = sext16;
        case (op)
            6'h0F:               imm_ext = DATA_W'($signed({imm16, 16'h0000}));
            6'h0C, 6'h0D, 6'h0E: imm_ext = LOGIC_SEXT ? sext16 : DATA_W'(imm16);
            default:             imm_ext = sext16;
        endcase
    end

    // Branch target wraps modulo 2^DATA_W; jump keeps the upper PC bits.
    always_comb begin
        btarget = bus.in_pc4 + (sext16 << 2);
        jtarget = {bus.in_pc4[DATA_W-1:28], bus.in_instr[25:0], 2'b00};
    end

    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              load;
    logic [5:0]        opcode_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [4:0]        shamt_q;
    logic [5:0]        funct_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] btarget_q;
    logic [DATA_W-1:0] jtarget_q;
    logic [DATA_W-1:0] pc4_q;

    logic advance;
    logic hazard;

    // Load-use detection against the instruction currently held in the register.
    always_comb begin
        advance = !valid_q || bus.out_ready;
        hazard  = bus.in_valid && valid_q && is_load(opcode_q) && (rt_q != 5'd0) &&
                  ((rt_q == rs) || (uses_rt(op) && (rt_q == rt)));
    end

    // Next-state control: flush beats everything, then bubble, capture or drain.
    always_comb begin
        valid_d = valid_q;
        stall_d = stall_q;
        load    = 1'b0;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            if (hazard) begin
                valid_d = 1'b0;
                if (stall_q != {CNT_W{1'b1}}) begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end else if (bus.in_valid) begin
                valid_d = 1'b1;
                load    = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    // ID/EX data fields; they hold across bubbles, flushes and backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            funct_q   <= '0;
            imm_q     <= '0;
            btarget_q <= '0;
            jtarget_q <= '0;
            pc4_q     <= '0;
        end else if (load) begin
            opcode_q  <= op;
            rs_q      <= rs;
            rt_q      <= rt;
            rd_q      <= rd;
            shamt_q   <= shamt;
            funct_q   <= funct;
            imm_q     <= imm_ext;
            btarget_q <= btarget;
            jtarget_q <= jtarget;
            pc4_q     <= bus.in_pc4;
        end
    end

    assign bus.in_ready    = advance && !hazard && !bus.flush;
    assign bus.hazard      = hazard;
    assign bus.out_valid   = valid_q;
    assign bus.out_opcode  = opcode_q;
    assign bus.out_rs      = rs_q;
    assign bus.out_rt      = rt_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_shamt   = shamt_q;
    assign bus.out_funct   = funct_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_btarget = btarget_q;
    assign bus.out_jtarget = jtarget_q;
    assign bus.out_pc4     = pc4_q;
    assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus a randomized run against a
// transaction-level reference model. dut1 uses LOGIC_SEXT=1 and a 2-bit stall counter.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    int exp_stalls;

    // Reference model state: the instruction the ID/EX register should hold.
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    int          m_stalls;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(32), .CNT_W(16)) bus0 ();
    decode_stage_pipe_if #(.DATA_W(32), .CNT_W(2))  bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_instr  = in_instr;
    assign bus0.in_pc4    = in_pc4;
    assign bus0.flush     = flush;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_instr  = in_instr;
    assign bus1.in_pc4    = in_pc4;
    assign bus1.flush     = flush;
    assign bus1.out_ready = out_ready;

    decode_stage_pipe #(.DATA_W(32), .CNT_W(16), .LOGIC_SEXT(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    decode_stage_pipe #(.DATA_W(32), .CNT_W(2), .LOGIC_SEXT(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input bit sext_logic);
        int unsigned op = ins[31:26];
        longint      v  = ins[15:0];
        if (op == 15) v = v * 65536;
        else if (op >= 12 && op <= 14 && !sext_logic) v = v;
        else if (v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_btarget(input logic [31:0] ins, input logic [31:0] pc4);
        longint s = ins[15:0];
        if (s >= 32768) s = s - 65536;
        return 32'(longint'(pc4) + 4 * s);
    endfunction

    function automatic logic [31:0] ref_jtarget(input logic [31:0] ins, input logic [31:0] pc4);
        return (pc4 & 32'hF000_0000) | (32'(ins[25:0]) * 4);
    endfunction

    function automatic bit ref_hazard(input bit iv, input logic [31:0] ins);
        int unsigned hop = m_instr[31:26];
        int unsigned hrt = m_instr[20:16];
        int unsigned nop = ins[31:26];
        bit ld  = hop inside {32, 33, 35, 36, 37};
        bit urt = nop inside {0, 4, 5, 40, 41, 43};
        return iv && m_valid && ld && hrt != 0 &&
               (hrt == ins[25:21] || (urt && hrt == ins[20:16]));
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_tick();
        bit adv = !m_valid || out_ready;
        bit hz  = ref_hazard(in_valid, in_instr);
        if (flush) m_valid = 0;
        else if (adv) begin
            if (hz) begin
                m_valid = 0;
                m_stalls++;
            end else if (in_valid) begin
                m_valid = 1;
                m_instr = in_instr;
                m_pc4   = in_pc4;
            end else m_valid = 0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        logic [5:0]  op;
        case ($urandom_range(0, 11))
            0: op = 6'h00;  1: op = 6'h04;  2: op = 6'h05;  3: op = 6'h23;
            4: op = 6'h20;  5: op = 6'h2B;  6: op = 6'h0F;  7: op = 6'h0C;
            8: op = 6'h0D;  9: op = 6'h02;  10: op = 6'h25;
            default: op = 6'($urandom);
        endcase
        ins[31:26] = op;
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc4 = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_stalls = 0;
        m_valid = 0; m_instr = '0; m_pc4 = '0; m_stalls = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc4 = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%h want=0", bus0.out_valid);
        end
        checks++;
        if (bus0.stall_count !== 16'd0) begin
            failures++; $display("FAIL reset_stall got=%h want=0", bus0.stall_count);
        end
        checks++;
        if (bus0.out_imm !== 32'd0 || bus0.out_pc4 !== 32'd0 || bus0.out_btarget !== 32'd0) begin
            failures++; $display("FAIL reset_fields imm=%h pc4=%h bt=%h want=0",
                                 bus0.out_imm, bus0.out_pc4, bus0.out_btarget);
        end
        checks++;
        if (bus0.hazard !== 1'b0 || bus0.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_comb hazard=%b in_ready=%b want 0/1",
                                 bus0.hazard, bus0.in_ready);
        end
        rst_n = 1'b1;
        exp_stalls = 0;
        tick();
    endtask

    task automatic test_lui();
        in_valid = 1'b1; in_instr = 32'h3C01_1234; in_pc4 = 32'h0040_0004;
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_rt !== 5'd1 || bus0.out_opcode !== 6'h0F) begin
            failures++; $display("FAIL lui_fields valid=%b rt=%h op=%h want 1/1/0f",
                                 bus0.out_valid, bus0.out_rt, bus0.out_opcode);
        end
        checks++;
        if (bus0.out_imm !== 32'h1234_0000 || bus0.out_pc4 !== 32'h0040_0004) begin
            failures++; $display("FAIL lui_imm imm=%h pc4=%h want 12340000/00400004",
                                 bus0.out_imm, bus0.out_pc4);
        end
        tick();
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++; $display("FAIL lui_drain got=%b want=0", bus0.out_valid);
        end
    endtask

    task automatic test_imm();
        in_valid = 1'b1; in_instr = 32'h3422_FFFF; in_pc4 = 32'h0040_0008;
        tick();
        checks++;
        if (bus0.out_imm !== 32'h0000_FFFF) begin
            failures++; $display("FAIL ori_zext got=%h want=0000ffff", bus0.out_imm);
        end
        checks++;
        if (bus1.out_imm !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL ori_sext got=%h want=ffffffff", bus1.out_imm);
        end
        in_instr = 32'h2003_FFFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_imm !== 32'hFFFF_FFFF || bus1.out_imm !== 32'hFFFF_FFFF ||
            bus0.out_rt !== 5'd3) begin
            failures++; $display("FAIL addi_imm imm0=%h imm1=%h rt=%h want ffffffff/ffffffff/3",
                                 bus0.out_imm, bus1.out_imm, bus0.out_rt);
        end
        tick();
    endtask

    task automatic test_targets();
        in_valid = 1'b1; in_pc4 = 32'h0040_0010; in_instr = 32'h1000_FFFE;
        tick();
        checks++;
        if (bus0.out_btarget !== 32'h0040_0008) begin
            failures++; $display("FAIL beq_target got=%h want=00400008", bus0.out_btarget);
        end
        in_instr = 32'h0810_0003;
        tick();
        checks++;
        if (bus0.out_jtarget !== 32'h0040_000C) begin
            failures++; $display("FAIL j_target got=%h want=0040000c", bus0.out_jtarget);
        end
        in_pc4 = 32'hFFFF_FFFC; in_instr = 32'h1000_0004;
        tick();
        checks++;
        if (bus0.out_btarget !== 32'h0000_000C) begin
            failures++; $display("FAIL btarget_wrap got=%h want=0000000c", bus0.out_btarget);
        end
        in_pc4 = 32'hA000_0000; in_instr = 32'h0BFF_FFFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_jtarget !== 32'hAFFF_FFFC) begin
            failures++; $display("FAIL j_upper got=%h want=affffffc", bus0.out_jtarget);
        end
        tick();
    endtask

    // lw $8,0($9) then add $10,$8,$11: one hazard cycle, one bubble, then the add.
    task automatic load_use_pair();
        in_valid = 1'b1; in_instr = 32'h8D28_0000; in_pc4 = 32'h0040_0020;
        tick();
        in_instr = 32'h010B_5020; in_pc4 = 32'h0040_0024;
        #1;
        checks++;
        if (bus0.hazard !== 1'b1 || bus0.in_ready !== 1'b0) begin
            failures++; $display("FAIL lu_hazard hazard=%b in_ready=%b want 1/0",
                                 bus0.hazard, bus0.in_ready);
        end
        tick();
        exp_stalls++;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.hazard !== 1'b0 || bus0.in_ready !== 1'b1) begin
            failures++; $display("FAIL lu_bubble valid=%b hazard=%b in_ready=%b want 0/0/1",
                                 bus0.out_valid, bus0.hazard, bus0.in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_rd !== 5'd10 || bus0.out_funct !== 6'h20) begin
            failures++; $display("FAIL lu_issue valid=%b rd=%h funct=%h want 1/0a/20",
                                 bus0.out_valid, bus0.out_rd, bus0.out_funct);
        end
    endtask

    task automatic test_load_use();
        load_use_pair();
        checks++;
        if (bus0.stall_count !== 16'(exp_stalls)) begin
            failures++; $display("FAIL lu_count got=%0d want=%0d", bus0.stall_count, exp_stalls);
        end
        // Load into $0 never stalls.
        in_valid = 1'b1; in_instr = 32'h8D20_0000;
        tick();
        in_instr = 32'h000B_5020;
        #1;
        checks++;
        if (bus0.hazard !== 1'b0 || bus0.in_ready !== 1'b1) begin
            failures++; $display("FAIL lu_zero hazard=%b in_ready=%b want 0/1",
                                 bus0.hazard, bus0.in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_rd !== 5'd10 ||
            bus0.stall_count !== 16'(exp_stalls)) begin
            failures++; $display("FAIL lu_zero_issue valid=%b rd=%h stalls=%0d want 1/0a/%0d",
                                 bus0.out_valid, bus0.out_rd, bus0.stall_count, exp_stalls);
        end
        tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) load_use_pair();
        tick();
        checks++;
        if (bus0.stall_count !== 16'(exp_stalls)) begin
            failures++; $display("FAIL sat_wide got=%0d want=%0d", bus0.stall_count, exp_stalls);
        end
        checks++;
        if (bus1.stall_count !== 2'(sat3(exp_stalls))) begin
            failures++; $display("FAIL sat_narrow got=%0d want=%0d",
                                 bus1.stall_count, sat3(exp_stalls));
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_instr = 32'h3422_FFFF; in_pc4 = 32'h0040_0030;
        tick();
        out_ready = 1'b0; in_instr = 32'h2003_FFFF; in_pc4 = 32'h0040_0034;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus0.in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_ready cycle=%0d got=%b want=0", i, bus0.in_ready);
            end
            tick();
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_imm !== 32'h0000_FFFF ||
                bus0.out_rt !== 5'd2 || bus0.out_pc4 !== 32'h0040_0030) begin
                failures++; $display("FAIL bp_hold cycle=%0d valid=%b imm=%h rt=%h pc4=%h", i,
                                     bus0.out_valid, bus0.out_imm, bus0.out_rt, bus0.out_pc4);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=%b want=1", bus0.in_ready);
        end
        tick();
        checks++;
        if (bus0.out_imm !== 32'hFFFF_FFFF || bus0.out_rt !== 5'd3) begin
            failures++; $display("FAIL bp_next imm=%h rt=%h want ffffffff/3",
                                 bus0.out_imm, bus0.out_rt);
        end
    endtask

    task automatic test_flush();
        // Register holds the addi from the previous scenario.
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h3C01_1234; in_pc4 = 32'h0040_0040;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_ready got=%b want=0", bus0.in_ready);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_imm !== 32'hFFFF_FFFF ||
            bus0.stall_count !== 16'(exp_stalls)) begin
            failures++; $display("FAIL flush_kill valid=%b imm=%h stalls=%0d want 0/ffffffff/%0d",
                                 bus0.out_valid, bus0.out_imm, bus0.stall_count, exp_stalls);
        end
        tick();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_imm !== 32'h1234_0000) begin
            failures++; $display("FAIL flush_retry valid=%b imm=%h want 1/12340000",
                                 bus0.out_valid, bus0.out_imm);
        end
        // Flush coinciding with a load-use hazard.
        in_instr = 32'h8D28_0000;
        tick();
        in_instr = 32'h010B_5020; flush = 1'b1;
        #1;
        checks++;
        if (bus0.hazard !== 1'b1 || bus0.in_ready !== 1'b0) begin
            failures++; $display("FAIL fh_comb hazard=%b in_ready=%b want 1/0",
                                 bus0.hazard, bus0.in_ready);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.stall_count !== 16'(exp_stalls)) begin
            failures++; $display("FAIL fh_wins valid=%b stalls=%0d want 0/%0d",
                                 bus0.out_valid, bus0.stall_count, exp_stalls);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_rd !== 5'd10 ||
            bus0.stall_count !== 16'(exp_stalls)) begin
            failures++; $display("FAIL fh_issue valid=%b rd=%h stalls=%0d want 1/0a/%0d",
                                 bus0.out_valid, bus0.out_rd, bus0.stall_count, exp_stalls);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = 32'h8D28_0000; in_pc4 = 32'h0040_0050;
        tick();
        in_instr = 32'h010B_5020;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.stall_count !== 16'd0 || bus0.out_imm !== 32'd0 ||
            bus0.out_pc4 !== 32'd0 || bus0.out_opcode !== 6'd0 || bus0.hazard !== 1'b0) begin
            failures++; $display("FAIL midreset valid=%b stalls=%0d imm=%h pc4=%h op=%h hz=%b",
                                 bus0.out_valid, bus0.stall_count, bus0.out_imm, bus0.out_pc4,
                                 bus0.out_opcode, bus0.hazard);
        end
        tick();
        rst_n = 1'b1;
        exp_stalls = 0;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_ready got=%b want=1", bus0.in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_rd !== 5'd10 || bus0.stall_count !== 16'd0) begin
            failures++; $display("FAIL midreset_issue valid=%b rd=%h stalls=%0d want 1/0a/0",
                                 bus0.out_valid, bus0.out_rd, bus0.stall_count);
        end
        tick();
    endtask

    task automatic test_random();
        bit exp_hz;
        bit exp_rdy;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc4    = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            exp_hz  = ref_hazard(in_valid, in_instr);
            exp_rdy = (!m_valid || out_ready) && !exp_hz && !flush;
            checks++;
            if (bus0.hazard !== exp_hz || bus0.in_ready !== exp_rdy) begin
                failures++; $display("FAIL rnd_comb i=%0d hazard=%b in_ready=%b want %b/%b",
                                     i, bus0.hazard, bus0.in_ready, exp_hz, exp_rdy);
            end
            model_tick();
            tick();
            checks++;
            if (bus0.out_valid !== m_valid || bus0.out_opcode !== m_instr[31:26] ||
                bus0.out_rs !== m_instr[25:21] || bus0.out_rt !== m_instr[20:16] ||
                bus0.out_rd !== m_instr[15:11] || bus0.out_shamt !== m_instr[10:6] ||
                bus0.out_funct !== m_instr[5:0] || bus0.out_pc4 !== m_pc4) begin
                failures++; $display("FAIL rnd_fields i=%0d valid=%b op=%h pc4=%h want %b/%h/%h",
                                     i, bus0.out_valid, bus0.out_opcode, bus0.out_pc4,
                                     m_valid, m_instr[31:26], m_pc4);
            end
            checks++;
            if (bus0.out_imm !== ref_imm(m_instr, 1'b0) ||
                bus1.out_imm !== ref_imm(m_instr, 1'b1)) begin
                failures++; $display("FAIL rnd_imm i=%0d imm0=%h imm1=%h want %h/%h", i,
                                     bus0.out_imm, bus1.out_imm,
                                     ref_imm(m_instr, 1'b0), ref_imm(m_instr, 1'b1));
            end
            checks++;
            if (bus0.out_btarget !== ref_btarget(m_instr, m_pc4) ||
                bus0.out_jtarget !== ref_jtarget(m_instr, m_pc4)) begin
                failures++; $display("FAIL rnd_targets i=%0d bt=%h jt=%h want %h/%h", i,
                                     bus0.out_btarget, bus0.out_jtarget,
                                     ref_btarget(m_instr, m_pc4), ref_jtarget(m_instr, m_pc4));
            end
            checks++;
            if (bus0.stall_count !== 16'(m_stalls) || bus1.stall_count !== 2'(sat3(m_stalls))) begin
                failures++; $display("FAIL rnd_stalls i=%0d s0=%0d s1=%0d want %0d/%0d", i,
                                     bus0.stall_count, bus1.stall_count, m_stalls,
                                     sat3(m_stalls));
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lui();
        test_imm();
        test_targets();
        test_load_use();
        test_saturate();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
